// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEY_W = 4;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned COL_W = $clog2(COLS);

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  // Index of the lowest-numbered active-low row; 0 when none is low.
  function automatic logic [ROW_W-1:0] lowest_low_row(input logic [ROWS-1:0] rows_n);
    logic [ROW_W-1:0] idx;
    idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = ROW_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Key output handshake: code/valid/overrun from the scanner, ready from the consumer.
interface keypad_scan_if;
  import keypad_pkg::*;

  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready;
  logic             overrun;

  modport master (output key_code, output key_valid, output overrun, input key_ready);
  modport slave  (input key_code, input key_valid, input overrun, output key_ready);

endinterface

// File: rtl/keypad_stable_timer.sv
// Saturating counter of stable cycles; done once Limit cycles have been counted.
module keypad_stable_timer #(
  parameter int unsigned Limit = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(Limit + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign done_o = (cnt_q == CntW'(Limit));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and a one-deep
// output register with ready/valid handshake and overrun reporting.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned DB_CYCLES = 4096
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_n,
  output logic [COLS-1:0] col_n,
  keypad_scan_if.master   key_if
);

  localparam int unsigned DivW = $clog2(SCAN_DIV);

  logic [ROWS-1:0]  row_s1_q, row_s2_q;
  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             tmr_clr, tmr_en, tmr_done;
  logic             offer;
  logic             row_hi;

  assign row_hi = row_s2_q[row_q];
  assign col_n  = ~(COLS'(1) << col_q);

  assign key_if.key_code  = code_q;
  assign key_if.key_valid = valid_q;
  assign key_if.overrun   = ovr_q;

  keypad_stable_timer #(
    .Limit (DB_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    offer   = 1'b0;
    unique case (state_q)
      StScan: begin
        tmr_clr = 1'b1;
        if (div_q == DivW'(SCAN_DIV - 1)) begin
          div_d = '0;
          if (row_s2_q != '1) begin
            row_d   = lowest_low_row(row_s2_q);
            state_d = StDebounce;
          end else begin
            col_d = col_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StDebounce: begin
        if (row_hi) begin
          tmr_clr = 1'b1;
          col_d   = col_q + 1'b1;
          state_d = StScan;
        end else if (tmr_done) begin
          state_d = StPressed;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StPressed: begin
        offer   = 1'b1;
        tmr_clr = 1'b1;
        state_d = StRelease;
      end
      StRelease: begin
        // Any low cycle restarts the release window.
        if (!row_hi) begin
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          col_d   = col_q + 1'b1;
          state_d = StScan;
        end else begin
          tmr_en = 1'b1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && key_if.key_ready) valid_d = 1'b0;
    if (offer) begin
      if (!valid_q || key_if.key_ready) begin
        code_d  = {row_q, col_q};
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1_q <= '1;
      row_s2_q <= '1;
      state_q  <= StScan;
      col_q    <= '0;
      row_q    <= '0;
      div_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      div_q    <= div_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench: a key matrix model drives row_n from col_n; expected codes are
// queued per scenario and a forked monitor checks each accepted handshake.
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int unsigned SCAN_DIV  = 8;
  localparam int unsigned DB_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] press = '0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;

  int total = 0;
  int bad = 0;
  int ovr_cnt = 0;
  logic [3:0] exp_q[$];

  keypad_scan_if key_if ();

  keypad_scan #(
    .SCAN_DIV  (SCAN_DIV),
    .DB_CYCLES (DB_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .row_n  (row_n),
    .col_n  (col_n),
    .key_if (key_if)
  );

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(press[r*4 +: 4] & ~col_n);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [3:0] idle_exp [4];
  logic [3:0] vals [4];
  int         gaps [4];
  logic [3:0] prev;
  int         since, nchg, run;
  logic       seen_valid, found;

  initial begin
    key_if.key_ready = 1'b1;
    idle_exp = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    vals = '{4'h0, 4'h0, 4'h0, 4'h0};
    gaps = '{0, 0, 0, 0};

    fork
      forever begin
        @(negedge clk);
        if (key_if.overrun) ovr_cnt++;
        if (key_if.key_valid && key_if.key_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_key: got %0h want none", key_if.key_code);
          end else begin
            check("key_code", 32'(key_if.key_code), 32'(exp_q.pop_front()));
          end
        end
      end
    join_none

    // Reset state
    cyc(3);
    check("rst_col_n", 32'(col_n), 32'(4'b1110));
    check("rst_key_valid", 32'(key_if.key_valid), 32'(1'b0));
    check("rst_key_code", 32'(key_if.key_code), 32'(4'h0));
    check("rst_overrun", 32'(key_if.overrun), 32'(1'b0));
    rst = 1'b0;

    // Idle scan: column sequence and dwell
    prev = col_n; since = 0; nchg = 0; seen_valid = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      since++;
      if (key_if.key_valid) seen_valid = 1'b1;
      if (col_n != prev) begin
        if (nchg < 4) begin
          vals[nchg] = col_n;
          gaps[nchg] = since;
        end
        nchg++;
        since = 0;
        prev = col_n;
      end
    end
    for (int i = 0; i < 4; i++) check("idle_col_seq", 32'(vals[i]), 32'(idle_exp[i]));
    for (int i = 1; i < 4; i++) check("idle_dwell", 32'(gaps[i]), 32'(SCAN_DIV));
    check("idle_no_valid", 32'(seen_valid), 32'(1'b0));

    // Held key 9 (row 2, col 1): one code, column frozen until release debounced
    exp_q.push_back(4'h9);
    press[9] = 1'b1;
    cyc(300);
    check("held_col_frozen", 32'(col_n), 32'(4'b1101));
    press = '0;
    cyc(12);
    check("release_col_frozen", 32'(col_n), 32'(4'b1101));
    cyc(12);
    check("release_next_col", 32'(col_n), 32'(4'b1011));
    cyc(40);
    check("held_one_code", 32'(exp_q.size()), 32'(0));

    // Bouncing contact then a solid press of key 3 (row 0, col 3)
    for (int i = 0; i < 10; i++) begin
      press[3] = ~press[3];
      cyc(3);
    end
    exp_q.push_back(4'h3);
    press[3] = 1'b1;
    cyc(100);
    press = '0;
    cyc(60);
    check("bounce_one_code", 32'(exp_q.size()), 32'(0));

    // 10-cycle glitch on key 0 caught at the col-0 sample point
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = col_n;
      cyc(1);
      if (prev != 4'b1110 && col_n == 4'b1110) found = 1'b1;
    end
    check("glitch_sync_found", 32'(found), 32'(1'b1));
    press[0] = 1'b1;
    cyc(9);
    check("glitch_col_held", 32'(col_n), 32'(4'b1110));
    cyc(1);
    press = '0;
    cyc(5);
    check("glitch_next_col", 32'(col_n), 32'(4'b1101));
    cyc(40);
    check("glitch_no_key", 32'(key_if.key_valid), 32'(1'b0));

    // Overrun: 9 held unread, 5 dropped
    key_if.key_ready = 1'b0;
    exp_q.push_back(4'h9);
    press[9] = 1'b1;
    cyc(80);
    press = '0;
    cyc(60);
    press[5] = 1'b1;
    cyc(80);
    press = '0;
    cyc(60);
    check("ovr_code_kept", 32'(key_if.key_code), 32'(4'h9));
    check("ovr_valid_kept", 32'(key_if.key_valid), 32'(1'b1));
    check("ovr_pulse_count", 32'(ovr_cnt), 32'(1));
    key_if.key_ready = 1'b1;
    cyc(1);
    key_if.key_ready = 1'b0;
    check("ready_clears_valid", 32'(key_if.key_valid), 32'(1'b0));
    check("ovr_queue_empty", 32'(exp_q.size()), 32'(0));

    // Two rows on col 2: lowest row wins
    key_if.key_ready = 1'b1;
    exp_q.push_back(4'h6);
    press[6] = 1'b1;
    press[14] = 1'b1;
    cyc(80);
    press = '0;
    cyc(60);
    check("multi_row_done", 32'(exp_q.size()), 32'(0));

    // Reset mid-debounce
    press[9] = 1'b1;
    run = 0; found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc(1);
      if (col_n == 4'b1101) run++;
      else run = 0;
      if (run >= 10) found = 1'b1;
    end
    check("debounce_reached", 32'(found), 32'(1'b1));
    rst = 1'b1;
    press = '0;
    cyc(1);
    rst = 1'b0;
    check("rst_db_col_n", 32'(col_n), 32'(4'b1110));
    check("rst_db_valid", 32'(key_if.key_valid), 32'(1'b0));
    check("rst_db_overrun", 32'(key_if.overrun), 32'(1'b0));
    cyc(80);
    check("rst_db_no_stale", 32'(exp_q.size()), 32'(0));

    // Reset with a pending key
    key_if.key_ready = 1'b0;
    press[9] = 1'b1;
    cyc(80);
    press = '0;
    cyc(40);
    check("pending_valid", 32'(key_if.key_valid), 32'(1'b1));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("rst_kv_col_n", 32'(col_n), 32'(4'b1110));
    check("rst_kv_valid", 32'(key_if.key_valid), 32'(1'b0));
    check("rst_kv_overrun", 32'(key_if.overrun), 32'(1'b0));
    key_if.key_ready = 1'b1;
    cyc(80);
    check("rst_kv_no_stale", 32'(key_if.key_valid), 32'(1'b0));
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_ovr_count", 32'(ovr_cnt), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, giving the clock cycles each column stays driven while scanning (minimum 4).
REQ-002 The block SHALL have parameter DB_CYCLES, default 4096, giving the consecutive stable cycles required to accept a press or a release (minimum 2).
REQ-003 The block SHALL have port clk  in  1  single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port row_n  in  4  asynchronous keypad rows, active-low, pulled up.
REQ-006 The block SHALL have port col_n  out  4  column drive, active-low, exactly one bit low at all times.
REQ-007 The block SHALL have port key_code  out  4  accepted key, row*4+col.
REQ-008 The block SHALL have port key_valid  out  1  key_code holds an unconsumed key.
REQ-009 The block SHALL have port key_ready  in  1  consumer accepts key_code when high together with key_valid.
REQ-010 The block SHALL have port overrun  out  1  one-cycle pulse when a key is dropped.

Function
REQ-011 row_n SHALL pass a 2-flop synchronizer; all row decisions use the synchronized value (2-cycle latency).
REQ-012 The FSM SHALL have states SCAN, DEBOUNCE, PRESSED and RELEASE.
REQ-013 SCAN: col_n = ~(1<<col_idx); col_idx SHALL advance every SCAN_DIV cycles and wrap from 3 to 0.
REQ-014 SCAN sampling: rows SHALL be sampled only on the last dwell cycle; if any is low, the block latches col_idx and the lowest-numbered low row, enters DEBOUNCE and holds the column.
REQ-015 DEBOUNCE: the stable counter SHALL count cycles with the latched row low; a high latched row SHALL return the FSM to SCAN with col_idx+1 (mod 4) and the counter cleared.
REQ-016 DEBOUNCE exit: when the counter reaches DB_CYCLES, the FSM SHALL enter PRESSED.
REQ-017 PRESSED: the block SHALL last exactly one cycle and offer code {row,col} to the output register, then enter RELEASE with the counter cleared.
REQ-018 RELEASE: the counter SHALL count consecutive cycles with the latched row high, and any low cycle SHALL clear it.
REQ-019 RELEASE exit: at DB_CYCLES the FSM SHALL return to SCAN at col_idx+1 (mod 4); a held key therefore yields exactly one code.
REQ-020 Output register: an offered code SHALL load key_code and set key_valid on the following cycle if key_valid is 0 or (key_valid and key_ready).
REQ-021 key_valid SHALL clear the cycle after key_valid and key_ready, unless a new load occurs in that same cycle.
REQ-022 key_code SHALL remain stable while key_valid is high and no load occurs.
REQ-023 If a code is offered while key_valid=1 and key_ready=0, the code SHALL be dropped, key_code/key_valid unchanged, and overrun high for exactly one cycle.
REQ-024 The counter SHALL saturate at DB_CYCLES and be ceil(log2(DB_CYCLES+1)) bits wide; the divider SHALL be sized for SCAN_DIV-1.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set state=SCAN, col_idx=0, col_n=4'b1110, key_code=0, key_valid=0, overrun=0, counters and synchronizer=all-ones/zero (rows idle high).
REQ-026 rst asserted in any state (including mid-DEBOUNCE/RELEASE or with key_valid=1) SHALL abandon the operation and discard the pending key.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, ROWS=4, COLS=4 and KEY_W=4.
REQ-028 The block SHALL contain one sub-module keypad_stable_timer (saturating stable-cycle counter with clear, count-enable and done), used by DEBOUNCE and RELEASE.

Verification
Bench parameters: SCAN_DIV=8, DB_CYCLES=16, 10 ns clock.
REQ-029 Idle, rows all high, 64 cycles -> col_n sequence 1110,1101,1011,0111,1110 every 8 cycles; key_valid stays 0.
REQ-030 Row 2 low while col 1 is driven, held 300 cycles, key_ready=1 -> exactly one key_valid pulse with key_code=4'h9, and col_n frozen at 1101 until 16 high cycles after release.
REQ-031 Row 0 toggling every 3 cycles for 30 cycles, then held low 100 cycles on col 3 -> exactly one key_code=4'h3; a 10-cycle low glitch alone -> no key_valid and scanning resumes at the next column.
REQ-032 key_ready=0, key 4'h9 pressed then released, then key 4'h5 pressed -> key_code stays 4'h9 and overrun pulses once; key_ready=1 for one cycle -> key_valid clears next cycle.
REQ-033 Rows 1 and 3 low together on col 2 -> key_code=4'h6 (lowest row wins).
REQ-034 rst=1 for 1 cycle mid-DEBOUNCE and again with key_valid=1 -> next cycle col_n=1110, key_valid=0, overrun=0, no stale code afterwards.
